spi_frame_receiver: RTL

//  SPI slave that receives the 24-bit DAC command frames {cmd[7:0], data[15:0]} sent by the sample output path.

---
 rtl/spi_frame_receiver_pkg.sv | 29 ++
 rtl/spi_frame_receiver_if.sv | 38 +++
 rtl/spi_frame_receiver_sync.sv | 45 ++++
 rtl/spi_frame_receiver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_receiver_pkg.sv
// +--------------------------------------------------------------------------+
// | spi_frame_receiver_pkg: frame geometry, DAC command bytes, FSM encoding  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package spi_frame_receiver_pkg;

    localparam int         c_CMD_WIDTH     = 8;
    localparam int         c_DATA_WIDTH    = 16;
    localparam int         c_BIT_CNT_WIDTH = 5;
    // Shared with the DAC transmit side; both ends must agree on these bytes.
    localparam logic [7:0] c_CMD_CHANNEL_A = 8'b0011_0001;
    localparam logic [7:0] c_CMD_CHANNEL_B = 8'b0011_0010;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DECODE    = 2'd3
    } rx_state_t;

    function automatic int frame_len(input int data_width);
        return c_CMD_WIDTH + data_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_frame_receiver_if.sv
// +--------------------------------------------------------------------------+
// | spi_frame_receiver_if: SPI pins in, decoded samples and strobes out      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface spi_frame_receiver_if
    import spi_frame_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) ();

    logic                  i_SPI_CS;
    logic                  i_SPI_Clock;
    logic                  i_SPI_Data;
    logic [DATA_WIDTH-1:0] o_Sample_A;
    logic [DATA_WIDTH-1:0] o_Sample_B;
    logic                  o_Valid_A;
    logic                  o_Valid_B;
    logic                  o_Pair_Valid;
    logic                  o_Frame_Error;
    logic [7:0]            o_Error_Count;

    modport master (
        output i_SPI_CS, i_SPI_Clock, i_SPI_Data,
        input  o_Sample_A, o_Sample_B, o_Valid_A, o_Valid_B,
               o_Pair_Valid, o_Frame_Error, o_Error_Count
    );

    modport slave (
        input  i_SPI_CS, i_SPI_Clock, i_SPI_Data,
        output o_Sample_A, o_Sample_B, o_Valid_A, o_Valid_B,
               o_Pair_Valid, o_Frame_Error, o_Error_Count
    );

endinterface

`default_nettype wire

// File: rtl/spi_frame_receiver_sync.sv
// +--------------------------------------------------------------------------+
// | spi_input_sync: 2-FF synchronisers for CS/SCK/MOSI, edge detect CS/SCK   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_input_sync (
    input  wire logic i_Clock,
    input  wire logic i_Reset,
    input  wire logic i_SPI_CS,
    input  wire logic i_SPI_Clock,
    input  wire logic i_SPI_Data,
    output logic      o_CS_Level,
    output logic      o_CS_Rise,
    output logic      o_CS_Fall,
    output logic      o_SCK_Rise,
    output logic      o_MOSI
);

    // Bit order in every stage: {MOSI, SCK, CS}
    logic [2:0] r_meta;
    logic [2:0] r_sync;
    logic [1:0] r_hist;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_meta <= 3'b000;
            r_sync <= 3'b000;
            r_hist <= 2'b00;
        end else begin
            r_meta <= {i_SPI_Data, i_SPI_Clock, i_SPI_CS};
            r_sync <= r_meta;
            r_hist <= r_sync[1:0];
        end
    end

    assign o_CS_Level = r_sync[0];
    assign o_CS_Rise  =  r_sync[0] & ~r_hist[0];
    assign o_CS_Fall  = ~r_sync[0] &  r_hist[0];
    assign o_SCK_Rise =  r_sync[1] & ~r_hist[1];
    assign o_MOSI     = r_sync[2];

endmodule

`default_nettype wire

// File: rtl/spi_frame_receiver.sv
// +--------------------------------------------------------------------------+
// | spi_frame_receiver: oversampled SPI slave decoding 24-bit DAC frames     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_frame_receiver
    import spi_frame_receiver_pkg::*;
#(
    parameter logic [7:0] CMD_CHANNEL_A = c_CMD_CHANNEL_A,
    parameter logic [7:0] CMD_CHANNEL_B = c_CMD_CHANNEL_B,
    parameter int         DATA_WIDTH    = c_DATA_WIDTH
) (
    input  wire logic            i_Clock,
    input  wire logic            i_Reset,
    spi_frame_receiver_if.slave  bus
);

    localparam int                         c_FRAME_LEN = frame_len(DATA_WIDTH);
    localparam logic [c_BIT_CNT_WIDTH-1:0] c_FRAME_CNT = c_BIT_CNT_WIDTH'(c_FRAME_LEN);

    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_rise;
    logic w_mosi;

    spi_input_sync u_sync (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_SPI_CS    (bus.i_SPI_CS),
        .i_SPI_Clock (bus.i_SPI_Clock),
        .i_SPI_Data  (bus.i_SPI_Data),
        .o_CS_Level  (w_cs_level),
        .o_CS_Rise   (w_cs_rise),
        .o_CS_Fall   (w_cs_fall),
        .o_SCK_Rise  (w_sck_rise),
        .o_MOSI      (w_mosi)
    );

    rx_state_t                   r_state;
    rx_state_t                   w_next_state;
    logic [c_FRAME_LEN-1:0]      r_shift;
    logic [c_BIT_CNT_WIDTH-1:0]  r_bit_cnt;
    logic                        r_pair_pending;

    logic [DATA_WIDTH-1:0]       r_sample_a;
    logic [DATA_WIDTH-1:0]       r_sample_b;
    logic                        r_valid_a;
    logic                        r_valid_b;
    logic                        r_pair_valid;
    logic                        r_frame_error;
    logic [7:0]                  r_error_count;

    logic                        w_clear;
    logic                        w_shift_en;
    logic                        w_accept_a;
    logic                        w_accept_b;
    logic                        w_reject;
    logic [c_CMD_WIDTH-1:0]      w_cmd;
    logic [DATA_WIDTH-1:0]       w_data;

    assign w_cmd  = r_shift[c_FRAME_LEN-1 -: c_CMD_WIDTH];
    assign w_data = r_shift[DATA_WIDTH-1:0];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift_en   = 1'b0;
        w_accept_a   = 1'b0;
        w_accept_b   = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            // Stay deaf until CS is seen high so we never lock onto a frame mid-way.
            ST_WAIT_IDLE: begin
                if (w_cs_level) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_next_state = ST_SHIFT;
                    w_clear      = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_shift_en = w_sck_rise;
                if (w_cs_rise) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next_state = ST_IDLE;
                if (r_bit_cnt == '0) begin
                    w_reject = 1'b0;
                end else if (r_bit_cnt != c_FRAME_CNT) begin
                    w_reject = 1'b1;
                end else if (w_cmd == CMD_CHANNEL_A) begin
                    w_accept_a = 1'b1;
                end else if (w_cmd == CMD_CHANNEL_B) begin
                    w_accept_b = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_pair_pending <= 1'b0;
            r_sample_a     <= '0;
            r_sample_b     <= '0;
            r_valid_a      <= 1'b0;
            r_valid_b      <= 1'b0;
            r_pair_valid   <= 1'b0;
            r_frame_error  <= 1'b0;
            r_error_count  <= 8'h00;
        end else begin
            r_valid_a     <= 1'b0;
            r_valid_b     <= 1'b0;
            r_pair_valid  <= 1'b0;
            r_frame_error <= 1'b0;

            if (w_clear) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[c_FRAME_LEN-2:0], w_mosi};
                if (r_bit_cnt != '1) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_accept_a) begin
                r_sample_a     <= w_data;
                r_valid_a      <= 1'b1;
                r_pair_pending <= 1'b1;
            end

            if (w_accept_b) begin
                r_sample_b <= w_data;
                r_valid_b  <= 1'b1;
                if (r_pair_pending) begin
                    r_pair_valid   <= 1'b1;
                    r_pair_pending <= 1'b0;
                end
            end

            if (w_reject) begin
                r_frame_error <= 1'b1;
                if (r_error_count != 8'hFF) begin
                    r_error_count <= r_error_count + 8'h01;
                end
            end
        end
    end

    assign bus.o_Sample_A    = r_sample_a;
    assign bus.o_Sample_B    = r_sample_b;
    assign bus.o_Valid_A     = r_valid_a;
    assign bus.o_Valid_B     = r_valid_b;
    assign bus.o_Pair_Valid  = r_pair_valid;
    assign bus.o_Frame_Error = r_frame_error;
    assign bus.o_Error_Count = r_error_count;

endmodule

`default_nettype wire
